// File: rtl/dac_req_arbiter_if.sv
// dac_req_arbiter_if: requester side and SPI-engine
// side signals of the DAC write arbiter.
interface dac_req_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req;
  logic [12*NREQ-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               busy;
  logic [1:0]         grant_id;
  logic [11:0]        data;
  logic [3:0]         address;
  logic [3:0]         command;
  logic               dactrig;
  logic               dacdone;
  logic               err;

  modport master (
    input  req, req_data, dacdone,
    output ack, busy, grant_id,
    output data, address, command,
    output dactrig, err
  );

  modport slave (
    output req, req_data, dacdone,
    input  ack, busy, grant_id,
    input  data, address, command,
    input  dactrig, err
  );
endinterface

// File: rtl/dac_req_arbiter.sv
// dac_req_arbiter: round-robin sharing of the DAC
// SPI write engine, with a done watchdog.
module dac_req_arbiter #(
  parameter int         NREQ    = 4,
  parameter logic [3:0] CMD     = 4'b0011,
  parameter int         TIMEOUT = 1023
) (
  input logic               CLK50MHZ,
  input logic               RST,
  dac_req_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, ACK
  } state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);
  localparam logic [1:0]  LAST = 2'(NREQ - 1);

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gid_q, gid_d;
  logic [11:0] data_q, data_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;

  logic [3:0]  req4;
  logic [2:0]  idx3;
  logic [1:0]  pick;
  logic        hit;
  logic [11:0] sel;

  // first pending request at or above ptr, wrapping at NREQ
  always_comb begin
    req4 = '0;
    req4[NREQ-1:0] = bus.req;
    idx3 = '0;
    hit  = 1'b0;
    pick = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      idx3 = {1'b0, ptr_q} + 3'(k);
      if (idx3 >= 3'(NREQ))
        idx3 = idx3 - 3'(NREQ);
      if (!hit && req4[idx3[1:0]]) begin
        hit  = 1'b1;
        pick = idx3[1:0];
      end
    end
  end

  // value of the requester being granted
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick == 2'(i))
        sel = bus.req_data[12*i +: 12];
  end

  // next state, grant capture and watchdog
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdog_d  = wdog_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          gid_d   = pick;
          data_d  = sel;
          addr_d  = {2'b00, pick};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        ptr_d   = (gid_q == LAST) ? 2'd0
                                  : gid_q + 2'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.dacdone) begin
          state_d = ACK;
        end else begin
          wdog_d = wdog_q + 16'd1;
          if (wdog_d == TO) begin
            err_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      data_q  <= '0;
      addr_q  <= 4'hF;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // one-hot completion pulse for the served requester
  always_comb begin
    bus.ack = '0;
    for (int i = 0; i < NREQ; i++)
      bus.ack[i] = (state_q == ACK) &&
                   (gid_q == 2'(i));
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.dactrig  = (state_q == ISSUE);
  assign bus.grant_id = gid_q;
  assign bus.data     = data_q;
  assign bus.address  = addr_q;
  assign bus.command  = CMD;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_dac_req_arbiter.sv
// tb_dac_req_arbiter: scoreboard bench for the
// DAC request arbiter with a simple engine model.
module tb_dac_req_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_r;
  logic [47:0] rdata_r;
  logic        done_r;

  dac_req_arbiter_if #(.NREQ(4)) bus ();

  assign bus.req      = req_r;
  assign bus.req_data = rdata_r;
  assign bus.dacdone  = done_r;

  dac_req_arbiter #(
    .NREQ(4),
    .CMD(4'b0011),
    .TIMEOUT(TO)
  ) dut (
    .CLK50MHZ(clk),
    .RST(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [11:0] val;
  } exp_t;

  exp_t        expq[$];
  int          n_run = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          req_t = -1;
  int          stray_cyc = -1;
  int          last_trig = 0;
  int          exp_ack_cyc = 0;
  int          eng_dly = 5;
  int          done_cnt = 0;
  bit          eng_on = 1'b1;
  bit          in_tx = 1'b0;
  bit          chk_idle = 1'b0;
  bit          exp_err = 1'b0;
  int          cur_id = 0;
  logic [11:0] cur_val = '0;
  logic [3:0]  drop = '0;
  logic [3:0]  rereq = '0;
  logic [3:0]  raise = '0;
  logic [11:0] rereq_val = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic put(input int id,
                     input logic [11:0] v);
    exp_t e;
    rdata_r[12*id +: 12] = v;
    e.id  = id;
    e.val = v;
    expq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    drop = '0;
    if (chk_idle) begin
      chk("idle_busy", bus.busy, 0);
      chk_idle = 1'b0;
    end
    if (in_tx && !eng_on && cyc == last_trig + TO)
      chk("err_early", bus.err, 0);
    if (in_tx && !eng_on && cyc == last_trig + TO + 1)
      exp_err = 1'b1;
    if (bus.dactrig) begin
      if (req_t >= 0) begin
        chk("trig_lat", cyc - req_t, 1);
        req_t = -1;
      end
      if (expq.size() == 0) begin
        chk("trig_unexp", 1, 0);
      end else begin
        e = expq.pop_front();
        cur_id  = e.id;
        cur_val = e.val;
        chk("gid", bus.grant_id, cur_id);
        chk("addr", bus.address, cur_id);
        chk("data", bus.data, cur_val);
        chk("cmd", bus.command, 3);
      end
      chk("err_trig", bus.err, exp_err);
      in_tx = 1'b1;
      last_trig = cyc;
      exp_ack_cyc = eng_on ? cyc + eng_dly + 1
                           : cyc + TO + 1;
      done_cnt = eng_on ? eng_dly : 0;
    end
    if (bus.ack != 0) begin
      if (!in_tx) begin
        chk("ack_unexp", bus.ack, 0);
      end else begin
        chk("ack", bus.ack, 32'(1) << cur_id);
        chk("ack_cyc", cyc, exp_ack_cyc);
        chk("addr_hold", bus.address, cur_id);
        chk("data_hold", bus.data, cur_val);
        chk("err_ack", bus.err, exp_err);
      end
      in_tx = 1'b0;
      chk_idle = 1'b1;
      drop = bus.ack;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (raise[i]) begin
        put(i, rereq_val);
        req_r[i] = 1'b1;
      end
    raise = drop & rereq;
    rereq = rereq & ~drop;
    req_r = req_r & ~drop;
    done_r = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0)
        done_r = 1'b1;
    end
    if (cyc + 1 == stray_cyc) begin
      done_r = 1'b1;
      stray_cyc = -1;
    end
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (expq.size() == 0 && !in_tx &&
          req_r == 0 && raise == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, ok, 1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    bit ok;
    rst_n   = 1'b1;
    req_r   = '0;
    rdata_r = '0;
    done_r  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data", bus.data, 0);
    chk("rst_addr", bus.address, 4'hF);
    chk("rst_cmd", bus.command, 4'h3);
    chk("rst_gid", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_trig", bus.dactrig, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_err", bus.err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    put(2, 12'hABC);
    req_r = 4'b0100;
    req_t = cyc + 1;
    wait_done("t1_done");

    rst_n = 1'b0;
    put(0, 12'h111);
    put(1, 12'h222);
    put(2, 12'h333);
    put(3, 12'h444);
    req_r = 4'hF;
    #1 rst_n = 1'b1;
    wait_done("t2_done");

    put(1, 12'h5A5);
    put(2, 12'h6B6);
    put(3, 12'h7C7);
    rereq = 4'b0010;
    rereq_val = 12'h9E1;
    req_r = 4'b1110;
    wait_done("t3_done");

    eng_on = 1'b0;
    put(0, 12'h0F0);
    req_r = 4'b0001;
    wait_done("t4_timeout");
    eng_on = 1'b1;
    eng_dly = 5;
    put(3, 12'h3C3);
    req_r = 4'b1000;
    wait_done("t4_after");
    chk("err_sticky", bus.err, 1);

    done_r = 1'b1;
    tick();
    chk("stray_busy", bus.busy, 0);
    chk("stray_ack", bus.ack, 0);
    eng_dly = 3;
    put(2, 12'h2D2);
    req_r = 4'b0100;
    req_t = cyc + 1;
    stray_cyc = cyc + 2;
    wait_done("t5_done");

    eng_dly = 5;
    put(1, 12'h1E1);
    req_r = 4'b0010;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (in_tx && cyc >= last_trig + 2) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_wait", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_trig", bus.dactrig, 0);
    chk("mrst_ack", bus.ack, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_err", bus.err, 0);
    chk("mrst_addr", bus.address, 4'hF);
    chk("mrst_data", bus.data, 0);
    expq.delete();
    in_tx    = 1'b0;
    done_cnt = 0;
    done_r   = 1'b0;
    exp_err  = 1'b0;
    rereq    = '0;
    raise    = '0;
    put(0, 12'hA01);
    put(1, 12'hA02);
    put(2, 12'hA03);
    put(3, 12'hA04);
    req_r = 4'hF;
    #1 rst_n = 1'b1;
    wait_done("t6_done");

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_req_arbiter.md
# dac_req_arbiter

Round-robin scheduler that shares the single DAC SPI write engine among up to four requesters, one per DAC channel. Each requester presents a 12-bit value and a request level. The arbiter grants one requester at a time, drives `data`, `address`, `command` and a `dactrig` pulse into the SPI engine, and waits for `dacdone`. It then acknowledges that requester and moves to the next. A watchdog flags an engine that never reports done.

## Interface
- `NREQ`, default 4: number of requesters, 1..4. Requester i writes DAC channel address i.
- `CMD`, default 4'b0011: command nibble issued with every write (write-and-update).
- `TIMEOUT`, default 1023: maximum cycles spent in WAIT before the watchdog fires. Legal range 1..65535.
- `CLK50MHZ`, in, 1: system clock. All logic is on the rising edge.
- `RST`, in, 1: reset, asynchronous, active-low.
- `req`, in, NREQ: per-requester request level. Held high until the matching `ack`.
- `req_data`, in, 12*NREQ: requester i's value in bits [12i+11:12i].
- `ack`, out, NREQ: one-cycle completion pulse, one-hot.
- `busy`, out, 1: high whenever the state is not IDLE.
- `grant_id`, out, 2: index of the requester currently or last served.
- `data`, out, 12: DAC code to the SPI engine.
- `address`, out, 4: DAC channel to the SPI engine.
- `command`, out, 4: DAC command to the SPI engine.
- `dactrig`, out, 1: one-cycle start pulse to the SPI engine.
- `dacdone`, in, 1: one-cycle completion pulse from the SPI engine.
- `err`, out, 1: sticky watchdog flag. Cleared only by reset.

## Operation
- State machine: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - No `req` bit high: stay in IDLE.
  - Otherwise grant the first set bit searching from `ptr` upward, wrapping modulo NREQ.
  - Register `grant_id`, `data = req_data[grant]`, `address = {2'b00, grant}`, `command = CMD`.
  - Go to ISSUE.
- **ISSUE**
  - `dactrig = 1` for exactly this cycle.
  - Clear the watchdog counter.
  - Set `ptr = (grant + 1) mod NREQ`.
  - Go to WAIT.
- **WAIT**
  - `dacdone = 1`: go to ACK.
  - Otherwise increment the 16-bit watchdog counter.
  - When the counter reaches TIMEOUT: set `err` and go to ACK. The transaction is abandoned but still acknowledged, so no requester deadlocks.
- **ACK**
  - `ack[grant_id] = 1` for this cycle.
  - Go to IDLE.
- `data`, `address`, `command` and `grant_id` hold their last issued values until the next grant. They never change during ISSUE, WAIT or ACK.
- A requester that drops `req` before it is granted is not served. `req_data` is sampled only on the IDLE-to-ISSUE edge.
- The requester must deassert `req` on the edge at which it samples `ack`.
- `dacdone` outside WAIT is ignored. This includes a `dacdone` coincident with `dactrig` in ISSUE.
- When NREQ < 4, unused `req` bits do not exist. `ptr` wraps at NREQ.

## Timing
- Reset values:
  - state IDLE, `ptr = 0`;
  - `data = 12'h000`, `address = 4'b1111`, `command = CMD`;
  - `dactrig = 0`, `ack = 0`, `busy = 0`, `grant_id = 0`, `err = 0`.
- Reset asserted mid-transaction (any state):
  - immediately return to IDLE;
  - no `ack` is issued, and any `dactrig` is dropped;
  - `err` is cleared.
- Latency: `req` high in an idle cycle T gives `dactrig` in T+1. `dacdone` in cycle D gives `ack` in D+1. IDLE is re-entered at D+2.
- Minimum transaction length is 4 cycles (IDLE, ISSUE, one WAIT cycle, ACK). Back-to-back grants are therefore spaced at least 4 cycles apart at `dactrig`.
- Fairness: with all NREQ requests held continuously, grants follow 0, 1, …, NREQ-1, 0, …. No requester waits more than NREQ-1 other transactions.
- Watchdog: `err` rises, and ACK is entered, TIMEOUT+1 cycles after the `dactrig` cycle.

## Test plan
- Single request, `req = 4'b0100`, `req_data` bits [35:24] = 12'hABC; engine returns `dacdone` 5 cycles after `dactrig`:
  - `dactrig` one cycle after `req`;
  - `data = 12'hABC`, `address = 4'h2`, `command = 4'h3`;
  - `ack = 4'b0100` one cycle after `dacdone`;
  - `busy` low again the cycle after `ack`.
- All four requests held from reset, values 12'h111, 12'h222, 12'h333, 12'h444 -> `address` sequence 0, 1, 2, 3 with matching data. Each `ack` is one-hot and in grant order.
- Requester 1 re-requests immediately after its ack while 2 and 3 are pending -> 2 and 3 are served before 1 again.
- `TIMEOUT = 8`, `dacdone` never asserted -> `err` goes high 9 cycles after `dactrig`, `ack` pulses, and `err` stays high through later successful writes.
- Stray `dacdone` pulses in IDLE and in the ISSUE cycle -> no `ack`, no state change. The real `dacdone` 3 cycles later completes the write normally.
- `RST` low during WAIT -> `dactrig`, `ack`, `busy` and `err` are 0 immediately; `address = 4'hF`, `data = 0`. After release, requester 0 wins a four-way request.
